// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA bus layout and default 800x600@60 timing constants.
// Referenced by the generator and by every stage that consumes the bus.
package vga_timing_gen_pkg;

  localparam int VGA_BUS_SIZE = 38;

  localparam int VGA_H_VISIBLE = 800;
  localparam int VGA_H_FPORCH  = 40;
  localparam int VGA_H_SYNC    = 128;
  localparam int VGA_H_BPORCH  = 88;
  localparam int VGA_V_VISIBLE = 600;
  localparam int VGA_V_FPORCH  = 1;
  localparam int VGA_V_SYNC    = 4;
  localparam int VGA_V_BPORCH  = 23;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  // Eight 100-pixel colour bars across the active line.
  function automatic logic [11:0] bar_rgb(input logic [10:0] h);
    logic [10:0] idx;
    logic [11:0] c;
    idx = h / 11'd100;
    case (idx)
      11'd0:   c = 12'hFFF;
      11'd1:   c = 12'hFF0;
      11'd2:   c = 12'h0FF;
      11'd3:   c = 12'h0F0;
      11'd4:   c = 12'hF0F;
      11'd5:   c = 12'hF00;
      11'd6:   c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: counter with wrap, plus sync/blank decoded from the
// next count so they stay aligned with the registered count.
module vga_axis_counter #(
  parameter int   VISIBLE  = 800,
  parameter int   FPORCH   = 40,
  parameter int   SYNC     = 128,
  parameter int   BPORCH   = 88,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [10:0] count_o,
  output logic [10:0] next_o,
  output logic        wrap_o,
  output logic        sync_o,
  output logic        blank_o
);

  localparam int TOTAL = VISIBLE + FPORCH + SYNC + BPORCH;
  localparam logic [10:0] LAST    = 11'(TOTAL - 1);
  localparam logic [10:0] VIS     = 11'(VISIBLE);
  localparam logic [10:0] SYNC_LO = 11'(VISIBLE + FPORCH);
  localparam logic [10:0] SYNC_HI = 11'(VISIBLE + FPORCH + SYNC);

  logic [10:0] count_q, count_d;
  logic        sync_q, sync_d;
  logic        blank_q, blank_d;
  logic        wrap;

  always_comb begin
    wrap    = en_i && (count_q == LAST);
    count_d = count_q;
    if (en_i) begin
      count_d = wrap ? 11'd0 : count_q + 11'd1;
    end
    blank_d = (count_d >= VIS);
    sync_d  = ((count_d >= SYNC_LO) && (count_d < SYNC_HI))
              ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      sync_q  <= ~SYNC_POL;
      blank_q <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;
  assign wrap_o  = wrap;
  assign sync_o  = sync_q;
  assign blank_o = blank_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA bus origin: counters, sync/blank, frame tick and frame counter.
// Define VGA_TEST_PATTERN_EN to drive colour bars on rgb.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FPORCH  = VGA_H_FPORCH,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BPORCH  = VGA_H_BPORCH,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FPORCH  = VGA_V_FPORCH,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BPORCH  = VGA_V_BPORCH,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [VGA_BUS_SIZE-1:0] vga_out,
  output logic                    frame_tick,
  output logic [15:0]             frame_cnt
);

  logic [10:0] h_cnt, h_nxt, v_cnt, v_nxt;
  logic        h_wrap, h_sync, h_blnk;
  logic        v_wrap, v_sync, v_blnk;
  logic        frame_tick_q;
  logic [15:0] frame_cnt_q;
  logic [11:0] rgb;
  vga_bus_t    bus;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FPORCH(H_FPORCH),
    .SYNC(H_SYNC), .BPORCH(H_BPORCH), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst), .en_i(1'b1),
    .count_o(h_cnt), .next_o(h_nxt), .wrap_o(h_wrap),
    .sync_o(h_sync), .blank_o(h_blnk)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FPORCH(V_FPORCH),
    .SYNC(V_SYNC), .BPORCH(V_BPORCH), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst), .en_i(h_wrap),
    .count_o(v_cnt), .next_o(v_nxt), .wrap_o(v_wrap),
    .sync_o(v_sync), .blank_o(v_blnk)
  );

  // Vertical wrap only fires on a line wrap, so it marks the next (0,0).
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_tick_q <= v_wrap;
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = 12'h000;
    if ((h_nxt < 11'(H_VISIBLE)) && (v_nxt < 11'(V_VISIBLE))) begin
      rgb_d = bar_rgb(h_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`else
  logic unused_nxt;
  assign unused_nxt = ^{h_nxt, v_nxt};
  assign rgb        = 12'h000;
`endif

  assign bus.hcount = h_cnt;
  assign bus.hsync  = h_sync;
  assign bus.hblnk  = h_blnk;
  assign bus.vcount = v_cnt;
  assign bus.vsync  = v_sync;
  assign bus.vblnk  = v_blnk;
  assign bus.rgb    = rgb;

  assign vga_out    = bus;
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: expected (cycle, field, value)
// entries are queued and checked by a negedge monitor.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  typedef enum {F_H, F_V, F_HS, F_VS, F_HB, F_VB,
                F_RGB, F_TICK, F_CNT} fld_e;
  typedef struct {
    int   at;
    fld_e f;
    int   exp;
  } exp_t;

  exp_t sbq[$];

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [VGA_BUS_SIZE-1:0] vga_out;
  logic                    frame_tick;
  logic [15:0]             frame_cnt;

  int cyc    = -1;
  int checks = 0;
  int errors = 0;

  // Short vertical timing: 20 lines per frame, 21120 cycles.
  localparam int LINE  = 1056;
  localparam int FRAME = LINE * 20;

  vga_timing_gen #(
    .V_VISIBLE(12), .V_FPORCH(1), .V_SYNC(4), .V_BPORCH(3)
  ) dut (
    .clk(clk), .rst(rst), .vga_out(vga_out),
    .frame_tick(frame_tick), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  function automatic int get(fld_e f);
    vga_bus_t b;
    b = vga_bus_t'(vga_out);
    case (f)
      F_H:     return int'(b.hcount);
      F_V:     return int'(b.vcount);
      F_HS:    return int'(b.hsync);
      F_VS:    return int'(b.vsync);
      F_HB:    return int'(b.hblnk);
      F_VB:    return int'(b.vblnk);
      F_RGB:   return int'(b.rgb);
      F_TICK:  return int'(frame_tick);
      F_CNT:   return int'(frame_cnt);
      default: return -1;
    endcase
  endfunction

  task automatic push(input int at, input fld_e f, input int exp);
    exp_t e;
    e.at  = at;
    e.f   = f;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   act;
    while (sbq.size() > 0 && cyc >= 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      checks++;
      act = get(e.f);
      if (e.at != cyc) begin
        errors++;
        $display("FAIL missed %s@%0d: now cycle %0d",
                 e.f.name(), e.at, cyc);
      end else if (act != e.exp) begin
        errors++;
        $display("FAIL %s@%0d: got 0x%0h expected 0x%0h",
                 e.f.name(), e.at, act, e.exp);
      end
    end
  end

  task automatic wait_cyc(input int target, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (cyc != target && n < budget);
    if (cyc != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: got %0d expected %0d", cyc, target);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sbq.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    // Reset state and first line / first frame.
    push(0, F_H, 0);      push(0, F_V, 0);
    push(0, F_HS, 0);     push(0, F_VS, 0);
    push(0, F_HB, 0);     push(0, F_VB, 0);
    push(0, F_RGB, 0);    push(0, F_TICK, 0);
    push(0, F_CNT, 0);
    push(1, F_H, 1);      push(1, F_TICK, 0);
    push(799, F_HB, 0);
    push(800, F_HB, 1);   push(800, F_HS, 0);
    push(839, F_HS, 0);   push(840, F_HS, 1);
    push(967, F_HS, 1);   push(968, F_HS, 0);
    push(1055, F_H, 1055); push(1055, F_V, 0);
    push(1055, F_HB, 1);
    push(LINE, F_H, 0);   push(LINE, F_V, 1);
    push(LINE, F_HB, 0);  push(LINE, F_HS, 0);
`ifdef VGA_TEST_PATTERN_EN
    push(10 * LINE, F_RGB, 12'hFFF);
    push(10 * LINE + 150, F_RGB, 12'hFF0);
`else
    push(10 * LINE, F_RGB, 0);
    push(10 * LINE + 150, F_RGB, 0);
`endif
    push(10 * LINE + 799, F_RGB, 0);
    push(10 * LINE + 810, F_RGB, 0);
    push(12 * LINE - 1, F_VB, 0);
    push(12 * LINE, F_VB, 1);  push(12 * LINE, F_VS, 0);
    push(12 * LINE, F_RGB, 0);
    push(13 * LINE - 1, F_VS, 0);
    push(13 * LINE, F_VS, 1);  push(13 * LINE, F_VB, 1);
    push(17 * LINE - 1, F_VS, 1);
    push(17 * LINE, F_VS, 0);  push(17 * LINE, F_VB, 1);
    push(FRAME - 1, F_H, 1055); push(FRAME - 1, F_V, 19);
    push(FRAME - 1, F_TICK, 0); push(FRAME - 1, F_CNT, 0);
    push(FRAME, F_H, 0);    push(FRAME, F_V, 0);
    push(FRAME, F_TICK, 1); push(FRAME, F_CNT, 1);
    push(FRAME, F_VB, 0);
    push(FRAME + 1, F_H, 1); push(FRAME + 1, F_TICK, 0);
    push(FRAME + 1, F_CNT, 1);

    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    wait_drain(FRAME + 100);

    // Mid-frame reset at (500,5) of the second frame.
    push(FRAME + 5 * LINE + 500, F_H, 500);
    push(FRAME + 5 * LINE + 500, F_V, 5);
    push(FRAME + 5 * LINE + 500, F_CNT, 1);
    wait_cyc(FRAME + 5 * LINE + 500, 10000);
    rst = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    push(0, F_H, 0);    push(0, F_V, 0);
    push(0, F_TICK, 0); push(0, F_CNT, 0);
    push(0, F_HS, 0);   push(0, F_HB, 0);
    push(1, F_H, 1);    push(1, F_TICK, 0);

    // Backdoor preload to exercise the 16-bit wrap.
    wait_cyc(2, 100);
    dut.frame_cnt_q = 16'hFFFF;
    push(5, F_CNT, 16'hFFFF);
    push(FRAME - 1, F_CNT, 16'hFFFF); push(FRAME - 1, F_TICK, 0);
    push(FRAME, F_TICK, 1); push(FRAME, F_CNT, 0);
    push(FRAME, F_H, 0);    push(FRAME, F_V, 0);
    push(FRAME + 1, F_TICK, 0); push(FRAME + 1, F_CNT, 0);
    wait_drain(FRAME + 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
